// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline definitions: pixel format, pooled map geometry and
// the state encoding of the feature-map replay buffer.
package lenet_pkg;

    localparam int DATA_W     = 8;
    localparam int CONV_MAP_W = 28;
    localparam int POOL_MAP_W = CONV_MAP_W / 2;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LAUNCH,
        ST_STREAM,
        ST_WAIT_ACK,
        ST_FINISH
    } replay_state_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port feature-map store: one write port, one read port with a
// single registered read stage (maps onto a block RAM with output reset).
module fmap_ram #(
    parameter int DEPTH  = 196,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fmap_replay_buffer.sv
// Captures one pooled feature map from the pool stream and replays it once
// per output filter of the next convolution layer.
module fmap_replay_buffer #(
    parameter int  MAP_WIDTH  = lenet_pkg::POOL_MAP_W,
    parameter int  DATA_W     = lenet_pkg::DATA_W,
    parameter int  NUM_PASSES = 16,
    localparam int PASS_W     = lenet_pkg::idx_w(NUM_PASSES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_done,
    input  logic              pass_ack,
    output logic              conv_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pixel,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              all_done,
    output logic              err_overflow,
    output logic              err_short
);

    import lenet_pkg::*;

    localparam int N      = MAP_WIDTH * MAP_WIDTH;
    localparam int ADDR_W = $clog2(N);

    replay_state_t     r_state;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [PASS_W-1:0] r_pass_idx;
    logic              r_conv_start;
    logic              r_out_valid;
    logic              r_all_done;
    logic              r_err_overflow;
    logic              r_err_short;

    logic              w_accepting;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_last_wr;
    logic              w_rd_en;
    logic              w_last_rd;
    logic              w_last_pass;
    logic [DATA_W-1:0] w_rd_data;

    assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
    assign w_wr_en     = in_valid && w_accepting;
    assign w_wr_addr   = (r_state == ST_CAPTURE) ? r_wr_cnt : '0;
    assign w_last_wr   = (r_state == ST_CAPTURE) && in_valid && (r_wr_cnt == ADDR_W'(N - 1));
    assign w_rd_en     = (r_state == ST_STREAM);
    assign w_last_rd   = (r_rd_cnt == ADDR_W'(N - 1));
    assign w_last_pass = (r_pass_idx == PASS_W'(NUM_PASSES - 1));

    fmap_ram #(
        .DEPTH  (N),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_rst     (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (in_pixel),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_pass_idx     <= '0;
            r_conv_start   <= 1'b0;
            r_out_valid    <= 1'b0;
            r_all_done     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_short    <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            r_all_done   <= 1'b0;
            // Read data lands one cycle after the address, so valid trails the read enable.
            r_out_valid  <= w_rd_en;
            if (in_valid && !w_accepting) begin
                r_err_overflow <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_wr_cnt <= ADDR_W'(1);
                        r_state  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // A final pixel wins over a same-cycle in_done.
                    if (w_last_wr) begin
                        r_wr_cnt     <= '0;
                        r_pass_idx   <= '0;
                        r_conv_start <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end else if (in_done) begin
                        r_err_short <= 1'b1;
                        r_wr_cnt    <= '0;
                        r_state     <= ST_IDLE;
                    end else if (in_valid) begin
                        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_rd_cnt <= '0;
                    r_state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                    if (w_last_rd) begin
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (pass_ack) begin
                        if (w_last_pass) begin
                            r_all_done <= 1'b1;
                            r_state    <= ST_FINISH;
                        end else begin
                            r_pass_idx   <= r_pass_idx + PASS_W'(1);
                            r_conv_start <= 1'b1;
                            r_state      <= ST_LAUNCH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_pass_idx <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_start   = r_conv_start;
    assign out_valid    = r_out_valid;
    assign out_pixel    = w_rd_data;
    assign pass_idx     = r_pass_idx;
    assign busy         = (r_state != ST_IDLE);
    assign all_done     = r_all_done;
    assign err_overflow = r_err_overflow;
    assign err_short    = r_err_short;

endmodule

// File: tb/tb_fmap_replay_buffer.sv
// Randomized bench for fmap_replay_buffer: a transaction-level model of the
// capture/replay timeline is compared against the DUT on every cycle.
module tb_fmap_replay_buffer;

    localparam int MW = 14;
    localparam int N  = MW * MW;
    localparam int NP = 3;
    localparam int PW = $clog2(NP);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_pixel;
    logic          in_done;
    logic          pass_ack;
    logic          conv_start;
    logic          out_valid;
    logic [7:0]    out_pixel;
    logic [PW-1:0] pass_idx;
    logic          busy;
    logic          all_done;
    logic          err_overflow;
    logic          err_short;

    fmap_replay_buffer #(
        .MAP_WIDTH  (MW),
        .DATA_W     (8),
        .NUM_PASSES (NP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_done      (in_done),
        .pass_ack     (pass_ack),
        .conv_start   (conv_start),
        .out_valid    (out_valid),
        .out_pixel    (out_pixel),
        .pass_idx     (pass_idx),
        .busy         (busy),
        .all_done     (all_done),
        .err_overflow (err_overflow),
        .err_short    (err_short)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode 0 idle, 1 capturing, 2 replaying a pass, 3 finish cycle.
    // During a pass, m_t counts cycles since the conv_start cycle.
    localparam int M_IDLE = 0, M_CAP = 1, M_PASS = 2, M_FIN = 3;
    logic [7:0] m_map [N];
    int  m_mode  = M_IDLE;
    int  m_cnt   = 0;
    int  m_pass  = 0;
    int  m_t     = 0;
    bit  m_ovf   = 0;
    bit  m_short = 0;
    bit  m_on    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_pass = 0; m_t = 0;
            m_ovf = 0; m_short = 0; m_on = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (in_valid) begin
                    m_map[0] = in_pixel; m_cnt = 1; m_mode = M_CAP;
                end
                M_CAP: begin
                    if (in_valid) begin m_map[m_cnt] = in_pixel; m_cnt++; end
                    if (m_cnt == N) begin m_mode = M_PASS; m_pass = 0; m_t = 0; end
                    else if (in_done) begin m_short = 1; m_mode = M_IDLE; end
                end
                M_PASS: begin
                    if (in_valid) m_ovf = 1;
                    if (m_t >= N + 1 && pass_ack) begin
                        if (m_pass == NP - 1) m_mode = M_FIN;
                        else begin m_pass++; m_t = 0; end
                    end else begin
                        m_t++;
                    end
                end
                default: begin
                    if (in_valid) m_ovf = 1;
                    m_pass = 0; m_mode = M_IDLE;
                end
            endcase
        end
    end

    // Compare process plus pulse bookkeeping used by the literal checks.
    bit         e_cs, e_ov, e_busy, e_ad;
    logic [7:0] e_px;
    int         n_cyc = 0, cs_cyc = 0, cs_count = 0, ov_count = 0, ad_count = 0, gap_ok = 0;
    bit         pend = 0;
    logic [7:0] first_pix = 8'h00;

    always @(negedge clk) begin
        n_cyc++;
        if (m_on) begin
            e_cs   = (m_mode == M_PASS) && (m_t == 0);
            e_ov   = (m_mode == M_PASS) && (m_t >= 2) && (m_t <= N + 1);
            e_px   = e_ov ? m_map[m_t - 2] : 8'h00;
            e_busy = (m_mode != M_IDLE);
            e_ad   = (m_mode == M_FIN);
            vectors++;
            if ({conv_start, out_valid, busy, all_done, err_overflow, err_short} !==
                    {e_cs, e_ov, e_busy, e_ad, m_ovf, m_short} ||
                pass_idx !== PW'(m_pass) || (e_ov && out_pixel !== e_px)) begin
                miscompares++;
                $display("FAIL cycle %0d: got cs=%b ov=%b px=%0d pi=%0d busy=%b done=%b eo=%b es=%b, expected cs=%b ov=%b px=%0d pi=%0d busy=%b done=%b eo=%b es=%b",
                         n_cyc, conv_start, out_valid, $signed(out_pixel), pass_idx, busy, all_done,
                         err_overflow, err_short, e_cs, e_ov, $signed(e_px), m_pass, e_busy, e_ad,
                         m_ovf, m_short);
            end
        end
        if (conv_start === 1'b1) begin pend = 1; cs_cyc = n_cyc; cs_count++; end
        if (out_valid === 1'b1) begin
            ov_count++;
            if (pend) begin
                pend = 0;
                if (n_cyc - cs_cyc == 2) gap_ok++;
                first_pix = out_pixel;
            end
        end
        if (all_done === 1'b1) ad_count++;
    end

    logic [7:0] tb_pix [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk_lit({tag, "_conv_start"}, 32'(conv_start), 0);
        chk_lit({tag, "_out_valid"}, 32'(out_valid), 0);
        chk_lit({tag, "_out_pixel"}, 32'(out_pixel), 0);
        chk_lit({tag, "_pass_idx"}, 32'(pass_idx), 0);
        chk_lit({tag, "_busy"}, 32'(busy), 0);
        chk_lit({tag, "_all_done"}, 32'(all_done), 0);
        chk_lit({tag, "_err_overflow"}, 32'(err_overflow), 0);
        chk_lit({tag, "_err_short"}, 32'(err_short), 0);
    endtask

    task automatic capture(input int n, input bit gapped, input bit done_with_last);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0; in_done = 1'b0; tick();
                end
            end
            in_valid = 1'b1;
            in_pixel = tb_pix[i];
            in_done  = done_with_last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_done  = 1'b0;
        if (!done_with_last) begin
            in_done = 1'b1; tick(); in_done = 1'b0;
        end
    endtask

    // Follows each pass by counting out_valid cycles; optionally injects an
    // overflow pixel or aborts with reset once abort_at pixels have been seen.
    task automatic run_passes(input int abort_at, input int ovf_pass);
        for (int p = 0; p < NP; p++) begin
            int seen   = 0;
            int budget = 0;
            while (1) begin
                if (out_valid === 1'b1) seen++;
                if (abort_at > 0 && seen == abort_at) begin
                    rst = 1'b1; in_valid = 1'b0; tick();
                    chk_reset("mid_stream_reset");
                    rst = 1'b0;
                    return;
                end
                in_valid = (p == ovf_pass) && (seen == 60);
                in_pixel = 8'($urandom);
                if (seen == N) break;
                tick();
                budget++;
                if (budget > 1000) begin
                    chk_lit("stream_timeout", 32'(seen), N);
                    in_valid = 1'b0;
                    return;
                end
            end
            in_valid = 1'b0;
            repeat ($urandom_range(0, 20)) tick();
            pass_ack = 1'b1; tick(); pass_ack = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'h00; in_done = 1'b0; pass_ack = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Gapped capture with in_done on the last pixel, overflow during pass 1.
        for (int i = 0; i < N; i++) tb_pix[i] = 8'(i % 128);
        cs_count = 0; ov_count = 0; ad_count = 0; gap_ok = 0;
        capture(N, 1'b1, 1'b1);
        chk_lit("launch_after_last_pixel", 32'(conv_start), 1);
        run_passes(0, 1);
        chk_lit("all_done_pulse", 32'(all_done), 1);
        tick();
        chk_lit("busy_after_finish", 32'(busy), 0);
        chk_lit("conv_start_count", 32'(cs_count), 3);
        chk_lit("out_valid_count", 32'(ov_count), 3 * N);
        chk_lit("all_done_count", 32'(ad_count), 1);
        chk_lit("first_pixel_gap_ok", 32'(gap_ok), 3);
        chk_lit("first_pixel_value", 32'(first_pix), 0);
        chk_lit("err_overflow_set", 32'(err_overflow), 1);

        // Short map: 100 pixels then in_done.
        for (int i = 0; i < N; i++) tb_pix[i] = 8'($urandom);
        capture(100, 1'b0, 1'b0);
        repeat (5) tick();
        chk_lit("err_short_set", 32'(err_short), 1);
        chk_lit("short_busy", 32'(busy), 0);
        chk_lit("short_no_conv_start", 32'(cs_count), 3);

        // Full random map; trailing in_done lands post-capture and is ignored.
        capture(N, 1'b0, 1'b0);
        run_passes(0, -1);
        tick();
        chk_lit("second_map_conv_starts", 32'(cs_count), 6);

        // Abort mid-stream, then a fresh capture starting with -128.
        for (int i = 0; i < N; i++) tb_pix[i] = 8'($urandom);
        tb_pix[0] = 8'h80;
        capture(N, 1'b0, 1'b1);
        run_passes(50, -1);
        tick();
        tb_pix[1] = 8'h7f;
        capture(N, 1'b1, 1'b1);
        run_passes(0, -1);
        tick();
        chk_lit("negative_pixel_replay", 32'(first_pix), 32'h80);
        chk_lit("errors_cleared_by_reset", 32'({err_overflow, err_short}), 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
